// File: rtl/stopwatch_uart_fmt_if.sv
// stopwatch_uart_fmt_if: valid/ready byte stream toward the UART transmitter
interface stopwatch_uart_fmt_if;
  logic [7:0] o_tx_data;
  logic o_tx_valid;
  logic i_tx_ready;
  modport master(output o_tx_data, output o_tx_valid, input i_tx_ready);
  modport slave(input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/stopwatch_uart_fmt.sv
// stopwatch_uart_fmt: snapshots stopwatch time on i_req and streams "HH:MM:SS.CC\r\n" over tx (FMT_RUN_FLAG_EN adds an "R "/"S " prefix)
module stopwatch_uart_fmt #(
  parameter int FRAME_LEN = 13
) (
  input logic clk,
  input logic rst,
  input logic [6:0] i_msec,
  input logic [5:0] i_sec,
  input logic [5:0] i_min,
  input logic [4:0] i_hour,
  input logic i_is_running,
  input logic i_req,
  stopwatch_uart_fmt_if.master tx,
  output logic o_busy,
  output logic o_done
);
`ifdef FMT_RUN_FLAG_EN
  localparam int N = FRAME_LEN + 2;
`else
  localparam int N = FRAME_LEN;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [3:0] idx, nidx;
  logic [7:0][3:0] dig, dn, nd;
  logic [6:0] cs;
  logic [7:0] next_byte;
  function automatic logic [7:0] body_byte(input logic [3:0] j, input logic [7:0][3:0] d);
    case (j)
      4'd0: return {4'h3, d[7]};
      4'd1: return {4'h3, d[6]};
      4'd2: return 8'h3A;
      4'd3: return {4'h3, d[5]};
      4'd4: return {4'h3, d[4]};
      4'd5: return 8'h3A;
      4'd6: return {4'h3, d[3]};
      4'd7: return {4'h3, d[2]};
      4'd8: return 8'h2E;
      4'd9: return {4'h3, d[1]};
      4'd10: return {4'h3, d[0]};
      4'd11: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction
  assign cs = i_msec > 7'd99 ? 7'd99 : i_msec;
  assign dn = {4'(i_hour / 5'd10), 4'(i_hour % 5'd10), 4'(i_min / 6'd10), 4'(i_min % 6'd10),
               4'(i_sec / 6'd10), 4'(i_sec % 6'd10), 4'(cs / 7'd10), 4'(cs % 7'd10)};
  assign nidx = state == IDLE ? 4'd0 : idx + 4'd1;
  assign nd = state == IDLE ? dn : dig;
`ifdef FMT_RUN_FLAG_EN
  logic run_q, nrun;
  assign nrun = state == IDLE ? i_is_running : run_q;
  assign next_byte = nidx == 4'd0 ? (nrun ? 8'h52 : 8'h53) : nidx == 4'd1 ? 8'h20 : body_byte(nidx - 4'd2, nd);
`else
  logic unused_run;
  assign unused_run = i_is_running;
  assign next_byte = body_byte(nidx, nd);
`endif
  assign o_busy = tx.o_tx_valid;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      dig <= '0;
`ifdef FMT_RUN_FLAG_EN
      run_q <= 1'b0;
`endif
      tx.o_tx_data <= 8'h00;
      tx.o_tx_valid <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (i_req) begin
          state <= SEND;
          idx <= nidx;
          dig <= dn;
`ifdef FMT_RUN_FLAG_EN
          run_q <= i_is_running;
`endif
          tx.o_tx_data <= next_byte;
          tx.o_tx_valid <= 1'b1;
        end
      end else if (tx.i_tx_ready) begin
        if (idx == 4'(N - 1)) begin
          state <= IDLE;
          idx <= '0;
          tx.o_tx_data <= 8'h00;
          tx.o_tx_valid <= 1'b0;
          o_done <= 1'b1;
        end else begin
          idx <= nidx;
          tx.o_tx_data <= next_byte;
        end
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_uart_fmt.sv
// tb_stopwatch_uart_fmt: random and directed frames checked against a string-formatting reference model
module tb_stopwatch_uart_fmt;
`ifdef FMT_RUN_FLAG_EN
  localparam int N = 15;
  localparam string LIT_BASIC = "S 01:02:03.45\r\n";
  localparam string LIT_SAT = "S 23:59:59.99\r\n";
`else
  localparam int N = 13;
  localparam string LIT_BASIC = "01:02:03.45\r\n";
  localparam string LIT_SAT = "23:59:59.99\r\n";
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic run = 1'b0;
  logic req = 1'b0;
  logic busy, done;
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] cap[$];
  bit m_done = 1'b0;
  bit m_zero = 1'b0;
  bit m_live = 1'b0;
  int c;
  stopwatch_uart_fmt_if tx();
  stopwatch_uart_fmt dut (
    .clk(clk), .rst(rst), .i_msec(msec), .i_sec(sec), .i_min(min), .i_hour(hour),
    .i_is_running(run), .i_req(req), .tx(tx), .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  function automatic string fmt(int h, int m, int s, int cc, bit r);
    string t, p;
    t = $sformatf("%02d:%02d:%02d.%02d\r\n", h, m, s, cc > 99 ? 99 : cc);
    p = r ? "R " : "S ";
    if (N == 15) t = {p, t};
    return t;
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    string t;
    if (!rst) begin
      q.delete();
      m_done = 1'b0;
      m_zero = 1'b1;
      m_live = 1'b1;
    end else begin
      m_done = 1'b0;
      if (q.size() == 0) begin
        if (req) begin
          t = fmt(int'(hour), int'(min), int'(sec), int'(msec), run);
          for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
          m_zero = 1'b0;
        end
      end else if (tx.i_tx_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", 8'(tx.o_tx_valid), 8'(q.size() != 0));
      chk("busy", 8'(busy), 8'(q.size() != 0));
      chk("done", 8'(done), 8'(m_done));
      if (q.size() != 0) chk("data", tx.o_tx_data, q[0]);
      else if (m_zero) chk("data_rst", tx.o_tx_data, 8'h00);
    end
  end
  always @(negedge clk) if (tx.o_tx_valid === 1'b1 && tx.i_tx_ready === 1'b1) cap.push_back(tx.o_tx_data);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input string name, input bit scramble, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (scramble) begin
        msec = 7'($urandom);
        sec = 6'($urandom);
        min = 6'($urandom);
        hour = 5'($urandom);
        run = 1'($urandom);
      end
    end while (done !== 1'b1 && cyc < 200);
    chk({name, "_done"}, 8'(done), 8'd1);
  endtask
  task automatic wait_cap(input int n);
    for (int k = 0; k < 200 && cap.size() < n; k++) tick();
    chk("cap_reach", 8'(cap.size()), 8'(n));
  endtask
  task automatic check_cap(input string name, input string e);
    chk({name, "_len"}, 8'(cap.size()), 8'(e.len()));
    for (int i = 0; i < e.len(); i++) chk($sformatf("%s[%0d]", name, i), i < cap.size() ? cap[i] : 8'hEE, e[i]);
  endtask
  initial begin
    tx.i_tx_ready = 1'b1;
    req = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 8'(tx.o_tx_valid), 8'd0);
      chk("rst_data", tx.o_tx_data, 8'h00);
      chk("rst_busy", 8'(busy), 8'd0);
    end
    rst = 1'b1;
    tick();
    req = 1'b0;
    chk("rel_start", 8'(tx.o_tx_valid), 8'd1);
    wait_done("rel", 1'b0, c);
    hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd45; run = 1'b0;
    tick();
    cap.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done("basic", 1'b0, c);
    chk("basic_lat", 8'(c), 8'(N));
    check_cap("basic", LIT_BASIC);
    tick();
    chk("basic_pulse", 8'(done), 8'd0);
    cap.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_cap(5);
    tx.i_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 8'(tx.o_tx_valid), 8'd1);
      chk("bp_hold", tx.o_tx_data, LIT_BASIC[5]);
    end
    tx.i_tx_ready = 1'b1;
    wait_done("bp", 1'b0, c);
    check_cap("bp", LIT_BASIC);
    tick();
    hour = 5'd23; min = 6'd59; sec = 6'd59; msec = 7'd120; run = 1'b0;
    cap.delete();
    req = 1'b1;
    tick();
    wait_done("sat", 1'b1, c);
    check_cap("sat", LIT_SAT);
    tick();
    chk("b2b_valid", 8'(tx.o_tx_valid), 8'd1);
    req = 1'b0;
    wait_done("b2b", 1'b1, c);
    tick();
    hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd45; run = 1'b0;
    cap.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_cap(6);
    rst = 1'b0;
    tick();
    chk("mid_valid", 8'(tx.o_tx_valid), 8'd0);
    chk("mid_done", 8'(done), 8'd0);
    rst = 1'b1;
    tick();
    chk("mid_done2", 8'(done), 8'd0);
    cap.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done("restart", 1'b0, c);
    check_cap("restart", LIT_BASIC);
`ifdef FMT_RUN_FLAG_EN
    for (int r = 1; r >= 0; r--) begin
      tick();
      run = 1'(r);
      cap.delete();
      req = 1'b1;
      tick();
      req = 1'b0;
      run = 1'(~r);
      wait_done("flag", 1'b0, c);
      chk("flag_len", 8'(cap.size()), 8'd15);
      chk("flag_lat", 8'(c), 8'd15);
      chk("flag_b0", cap[0], r ? 8'h52 : 8'h53);
      chk("flag_b1", cap[1], 8'h20);
    end
`endif
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) != 0;
      req = $urandom_range(0, 2) == 0;
      tx.i_tx_ready = $urandom_range(0, 3) != 0;
      msec = 7'($urandom);
      sec = 6'($urandom);
      min = 6'($urandom);
      hour = 5'($urandom);
      run = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    req = 1'b0;
    tx.i_tx_ready = 1'b1;
    repeat (N + 3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
